calltrace_dump: RTL
===================

Name: calltrace_dump

Overview:
- Reader engine at the far end of the calltrace data/status port.
- On a start pulse (trap or error handler, or a software strobe), it freezes the calltrace stack and reads out every stacked LNK entry.
- Entries are serialized as a framed byte stream on a valid/ready interface, which feeds the RS232 transmitter or the log buffer.
- The dump is non-destructive while frozen; after the dump the stack is released as selected by the optional feature.

Parameters:
- HEADER, 8'hCA, first byte of every frame.
- MAX_ENTRIES, 64, upper limit on entries dumped; the reported count is clipped to this value.
- DATA_WIDTH, 24, width of one stack entry in bits; always sent as 3 bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  dump request, single-cycle pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame is complete and the release command has been issued.
- ct_wr_ctrl  out  1  control write strobe to the calltrace.
- ct_ctrl  out  24  calltrace control word: bit0 clear, bit1 freeze, bit2 unfreeze.
- ct_rd_data  out  1  read strobe; advances the calltrace read position.
- ct_data_in  in  32  calltrace data_out; bits [23:0] hold the current entry.
- ct_status_in  in  32  calltrace status_out: [23:16] max_count, [15:8] count, [3] frozen, [0] empty.
- tx_data  out  8  stream byte.
- tx_valid  out  1  stream byte valid.
- tx_ready  in  1  sink accepts the byte.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-dump aborts to IDLE immediately and issues no release command; the stack stays frozen, and software must unfreeze or clear it.
- All outputs are registered.
- IDLE:
  - start=1 moves to FREEZE.
  - start is ignored when busy=1.
- FREEZE: one cycle with ct_wr_ctrl=1 and ct_ctrl=24'h000002. Then WAIT2.
- WAIT2: two idle cycles, then SAMPLE.
- SAMPLE:
  - n = min(ct_status_in[15:8], MAX_ENTRIES).
  - Clear the checksum register; load the entry counter with n.
  - Go to HDR.
- HDR: present HEADER. Then CNT: present n[7:0], which is included in the checksum.
- Stream handshake:
  - A byte transfers on a cycle where tx_valid and tx_ready are both 1.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - tx_valid may be asserted without waiting for tx_ready; back-to-back transfers run at one byte per cycle.
- LOAD (entered only when the counter is nonzero):
  - Capture ct_data_in[23:0] into the shift register.
  - Assert ct_rd_data for exactly this one cycle.
  - Decrement the counter.
  - Go to SEND.
- SEND:
  - Emit 3 bytes, MSB first: [23:16], [15:8], [7:0]. Each byte is XORed into the checksum.
  - After the third transfer: if the counter is nonzero, insert one gap cycle (the stack read settles), then LOAD; otherwise go to CSUM.
- CSUM: present the checksum byte, which is the XOR of the count byte and all entry bytes, excluding HEADER. Then REL.
- REL: one cycle with ct_wr_ctrl=1 and the release word (see Optional Feature). Next cycle: done=1, busy=0, state IDLE.
- ct_status_in[0] (empty) is ignored after SAMPLE; exactly n entries are always read.
- Only one of ct_wr_ctrl or ct_rd_data is ever asserted in a given cycle.

Optional Feature:
- Macro CALLTRACE_DUMP_CLEAR_EN.
- Defined: the REL word is 24'h000001; the stack is cleared after the dump.
- Undefined: the REL word is 24'h000004; the stack is unfrozen with its contents intact.

Test Plan:
- Three entries 0x000100, 0x000200, 0x123456 with tx_ready=1 -> stream CA 03 00 01 00 00 02 00 12 34 56 70; exactly 3 ct_rd_data pulses; done once.
- Empty stack (count 0) -> stream CA 00 00; no ct_rd_data pulse; REL write issued; done.
- tx_ready held 0 for 5 cycles on the second byte of an entry -> tx_data and tx_valid stable for all 5 cycles; no extra ct_rd_data; byte order unchanged.
- start pulsed again mid-dump -> ignored; frame identical to the no-restart run; one done only.
- rst asserted during SEND -> next cycle all outputs 0, state IDLE; no ct_wr_ctrl release; a new start runs a full frame.
- Count field 70 with MAX_ENTRIES=64 -> count byte 0x40; 64 ct_rd_data pulses. Release word: 0x000004 with the macro undefined, 0x000001 with it defined.

Source files
------------

// File: rtl/calltrace_dump_if.sv
// Calltrace data/status port plus the outgoing byte stream, as seen by the dump engine.
interface calltrace_dump_if;
    logic        ct_wr_ctrl;
    logic [23:0] ct_ctrl;
    logic        ct_rd_data;
    logic [31:0] ct_data_in;
    logic [31:0] ct_status_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output ct_wr_ctrl, ct_ctrl, ct_rd_data, tx_data, tx_valid,
        input  ct_data_in, ct_status_in, tx_ready
    );

    modport slave (
        input  ct_wr_ctrl, ct_ctrl, ct_rd_data, tx_data, tx_valid,
        output ct_data_in, ct_status_in, tx_ready
    );
endinterface

// File: rtl/calltrace_dump.sv
// Freezes the calltrace stack, streams HEADER/count/entries/checksum as bytes, then releases the stack.
// Define CALLTRACE_DUMP_CLEAR_EN to clear the stack after the dump instead of unfreezing it.
module calltrace_dump #(
    parameter logic [7:0]  HEADER      = 8'hCA,
    parameter int unsigned MAX_ENTRIES = 64,
    parameter int unsigned DATA_WIDTH  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    calltrace_dump_if.master  bus
);

    localparam logic [23:0] FREEZE_WORD = 24'h000002;
`ifdef CALLTRACE_DUMP_CLEAR_EN
    localparam logic [23:0] REL_WORD    = 24'h000001;
`else
    localparam logic [23:0] REL_WORD    = 24'h000004;
`endif
    localparam logic [7:0]  MAX_CNT     = 8'(MAX_ENTRIES);

    typedef enum logic [3:0] {
        IDLE, FREEZE, WAIT2, SAMPLE, HDR, CNT, LOAD, SEND, GAP, CSUM, REL
    } state_t;

    state_t                  state_r, state_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    wr_ctrl_r, wr_ctrl_s;
    logic [23:0]             ctrl_r, ctrl_s;
    logic                    rd_data_r, rd_data_s;
    logic [7:0]              tx_data_r, tx_data_s;
    logic                    tx_valid_r, tx_valid_s;
    logic [7:0]              cnt_r, cnt_s;
    logic [7:0]              csum_r, csum_s;
    logic [DATA_WIDTH-1:0]   shreg_r, shreg_s;
    logic [1:0]              idx_r, idx_s;
    logic                    wait_r, wait_s;
    logic                    xfer_s;
    logic                    unused_bits;

    function automatic logic [7:0] clip_count(input logic [7:0] raw);
        return (raw > MAX_CNT) ? MAX_CNT : raw;
    endfunction

    assign xfer_s = tx_valid_r & bus.tx_ready;

    // Next state, datapath and output-register values
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        wr_ctrl_s  = 1'b0;
        ctrl_s     = 24'h000000;
        rd_data_s  = 1'b0;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        cnt_s      = cnt_r;
        csum_s     = csum_r;
        shreg_s    = shreg_r;
        idx_s      = idx_r;
        wait_s     = wait_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = FREEZE;
                    busy_s    = 1'b1;
                    wr_ctrl_s = 1'b1;
                    ctrl_s    = FREEZE_WORD;
                end else begin
                    state_s   = IDLE;
                end
            end
            FREEZE: begin
                state_s = WAIT2;
                wait_s  = 1'b0;
            end
            WAIT2: begin
                if (wait_r) begin
                    state_s = SAMPLE;
                end else begin
                    wait_s  = 1'b1;
                end
            end
            SAMPLE: begin
                cnt_s      = clip_count(bus.ct_status_in[15:8]);
                csum_s     = 8'h00;
                state_s    = HDR;
                tx_valid_s = 1'b1;
                tx_data_s  = HEADER;
            end
            HDR: begin
                if (xfer_s) begin
                    state_s   = CNT;
                    tx_data_s = cnt_r;
                end else begin
                    state_s   = HDR;
                end
            end
            CNT: begin
                if (xfer_s) begin
                    csum_s = csum_r ^ tx_data_r;
                    if (cnt_r != 8'd0) begin
                        state_s    = LOAD;
                        tx_valid_s = 1'b0;
                        rd_data_s  = 1'b1;
                    end else begin
                        state_s    = CSUM;
                        tx_data_s  = csum_r ^ tx_data_r;
                    end
                end else begin
                    state_s = CNT;
                end
            end
            // The read strobe is high during this cycle; the entry is captured before the stack advances
            LOAD: begin
                shreg_s    = bus.ct_data_in[DATA_WIDTH-1:0];
                cnt_s      = cnt_r - 8'd1;
                idx_s      = 2'd0;
                state_s    = SEND;
                tx_valid_s = 1'b1;
                tx_data_s  = bus.ct_data_in[23:16];
            end
            SEND: begin
                if (xfer_s) begin
                    csum_s = csum_r ^ tx_data_r;
                    if (idx_r == 2'd2) begin
                        if (cnt_r != 8'd0) begin
                            state_s    = GAP;
                            tx_valid_s = 1'b0;
                        end else begin
                            state_s    = CSUM;
                            tx_data_s  = csum_r ^ tx_data_r;
                        end
                    end else begin
                        idx_s     = idx_r + 2'd1;
                        tx_data_s = (idx_r == 2'd0) ? shreg_r[15:8] : shreg_r[7:0];
                    end
                end else begin
                    state_s = SEND;
                end
            end
            GAP: begin
                state_s   = LOAD;
                rd_data_s = 1'b1;
            end
            CSUM: begin
                if (xfer_s) begin
                    state_s    = REL;
                    tx_valid_s = 1'b0;
                    tx_data_s  = 8'h00;
                    wr_ctrl_s  = 1'b1;
                    ctrl_s     = REL_WORD;
                end else begin
                    state_s    = CSUM;
                end
            end
            REL: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            default: begin
                state_s    = IDLE;
                busy_s     = 1'b0;
                tx_valid_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_ctrl_r  <= 1'b0;
            ctrl_r     <= 24'h000000;
            rd_data_r  <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            cnt_r      <= 8'h00;
            csum_r     <= 8'h00;
            shreg_r    <= '0;
            idx_r      <= 2'd0;
            wait_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            wr_ctrl_r  <= wr_ctrl_s;
            ctrl_r     <= ctrl_s;
            rd_data_r  <= rd_data_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            cnt_r      <= cnt_s;
            csum_r     <= csum_s;
            shreg_r    <= shreg_s;
            idx_r      <= idx_s;
            wait_r     <= wait_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign bus.ct_wr_ctrl = wr_ctrl_r;
    assign bus.ct_ctrl    = ctrl_r;
    assign bus.ct_rd_data = rd_data_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.tx_valid   = tx_valid_r;

    assign unused_bits = ^{bus.ct_data_in[31:24], bus.ct_status_in[31:16], bus.ct_status_in[7:0]};

endmodule
